// File: rtl/binary_to_bcd.sv
// 8-bit binary to 3-digit BCD converter using a serial shift-add-3 (double-dabble) datapath.
// Define BIN2BCD_CLEAR_ON_START_EN to zero the digit outputs from the capture edge until completion.
module binary_to_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] number,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] adj_s;
  logic [19:0] step_s;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      add3 = nib + 4'd3;
    end else begin
      add3 = nib;
    end
  endfunction

  // One double-dabble step: correct each nibble, then shift {scratch, shift} left.
  always_comb begin
    adj_s  = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    step_s = {adj_s[10:0], shift_q, 1'b0};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d   = number;
          scratch_d = 12'd0;
          cnt_d     = 3'd0;
          state_d   = ST_CONVERT;
          busy_d    = 1'b1;
`ifdef BIN2BCD_CLEAR_ON_START_EN
          ones_d     = 4'd0;
          tens_d     = 4'd0;
          hundreds_d = 4'd0;
`else
          ones_d     = ones_q;
          tens_d     = tens_q;
          hundreds_d = hundreds_q;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_CONVERT: begin
        scratch_d = step_s[19:8];
        shift_d   = step_s[7:0];
        cnt_d     = cnt_q + 3'd1;
        // The eighth step's shifted scratch already holds the final digits.
        if (cnt_q == 3'd7) begin
          hundreds_d = step_s[19:16];
          tens_d     = step_s[15:12];
          ones_d     = step_s[11:8];
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      scratch_q  <= 12'd0;
      cnt_q      <= 3'd0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hundreds_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: directed scenarios, an exhaustive sweep and random conversions,
// with expected digits computed by decimal division.
module tb_binary_to_bcd;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] number;
  logic [3:0] ones, tens, hundreds;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  int exp_h  = 0;
  int exp_t  = 0;
  int exp_o  = 0;
  time last_done_t = 0;

  binary_to_bcd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .number   (number),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_digits(input string tag, input int h, input int t, input int o);
    chk({tag, "_hundreds"}, int'(hundreds), h);
    chk({tag, "_tens"}, int'(tens), t);
    chk({tag, "_ones"}, int'(ones), o);
  endtask

  // Called at a negedge; returns at the negedge where done should be high.
  task automatic conv(input logic [7:0] n, input bit poke_start, input int abort_step);
    int busy_h, busy_t, busy_o;
`ifdef BIN2BCD_CLEAR_ON_START_EN
    busy_h = 0; busy_t = 0; busy_o = 0;
`else
    busy_h = exp_h; busy_t = exp_t; busy_o = exp_o;
`endif
    start  = 1'b1;
    number = n;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == abort_step) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk_digits("abort", 0, 0, 0);
        exp_h = 0; exp_t = 0; exp_o = 0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("abort_hold_done", int'(done), 0);
        end
        rst_n = 1'b1;
        return;
      end
      chk("conv_busy", int'(busy), 1);
      chk("conv_done", int'(done), 0);
      chk_digits("conv_during", busy_h, busy_t, busy_o);
      number = 8'($urandom);
      start  = (poke_start && k == 2) ? 1'b1 : 1'b0;
      if (poke_start && k == 2) number = 8'd0;
      @(negedge clk);
    end
    start  = 1'b0;
    exp_h  = int'(n) / 100;
    exp_t  = (int'(n) / 10) % 10;
    exp_o  = int'(n) % 10;
    chk("done_pulse", int'(done), 1);
    chk("done_busy", int'(busy), 0);
    chk_digits("result", exp_h, exp_t, exp_o);
    chk("identity", int'(hundreds) * 100 + int'(tens) * 10 + int'(ones), int'(n));
    last_done_t = $time;
  endtask

  // One idle cycle after a completion: done must drop and digits must hold.
  task automatic idle_check();
    @(negedge clk);
    chk("done_single", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk_digits("hold", exp_h, exp_t, exp_o);
  endtask

  initial begin
    time t_first;
    rst_n  = 1'b0;
    start  = 1'b0;
    number = 8'd0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_digits("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    conv(8'd0, 1'b0, -1);
    idle_check();

    conv(8'd239, 1'b0, -1);
    idle_check();
    conv(8'd111, 1'b0, -1);
    idle_check();
    conv(8'd255, 1'b0, -1);
    idle_check();

    // start pulsed while busy must be ignored
    conv(8'd239, 1'b1, -1);
    idle_check();
    idle_check();

    // back-to-back: start asserted in the done cycle
    conv(8'd111, 1'b0, -1);
    t_first = last_done_t;
    conv(8'd255, 1'b0, -1);
    chk("b2b_spacing_clks", int'((last_done_t - t_first) / 10), 9);
    idle_check();

    // reset mid-conversion at step 4
    conv(8'd255, 1'b0, 4);
    @(negedge clk);
    chk("post_abort_done", int'(done), 0);
    chk_digits("post_abort", 0, 0, 0);
    conv(8'd111, 1'b0, -1);
    idle_check();

    for (int v = 0; v < 256; v++) begin
      conv(8'(v), 1'b0, -1);
    end
    idle_check();

    for (int r = 0; r < 20; r++) begin
      conv(8'($urandom_range(255, 0)), 1'b0, -1);
      if (($urandom & 1) == 0) idle_check();
    end
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd.md
BINARY_TO_BCD -- requirements
Module: binary_to_bcd

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled on rising clk.
REQ-005 number  input  8  unsigned binary operand, 0..255.
REQ-006 ones  output  4  BCD units digit, 0..9.
REQ-007 tens  output  4  BCD tens digit, 0..9.
REQ-008 hundreds  output  4  BCD hundreds digit, 0..2.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when new digits are valid.

Function
REQ-011 The block SHALL use a two-state FSM:
- IDLE: busy=0.
- CONVERT: busy=1.
REQ-012 Capture edge: in IDLE with start=1 at a rising edge, the block SHALL:
- capture number into an internal 8-bit shift register;
- clear a 12-bit BCD scratch register and a 3-bit step counter;
- enter CONVERT.
REQ-013 In CONVERT, each rising edge SHALL perform one shift-add-3 (double-dabble) step:
- each scratch nibble >= 5 is incremented by 3;
- then {scratch, shift register} is shifted left by one bit.
REQ-014 On the 8th step edge, the block SHALL:
- load ones/tens/hundreds from the final scratch nibbles;
- assert done for exactly one cycle;
- return to IDLE with busy=0.
REQ-015 Latency SHALL be exactly 8 clocks from the capture edge to the edge that asserts done.
REQ-016 start while busy=1 SHALL be ignored, and number changes during CONVERT SHALL NOT affect the result.
REQ-017 start=1 in the cycle where done=1 SHALL be accepted (IDLE), so back-to-back conversions repeat every 9 clocks.
REQ-018 Outputs SHALL be registered and SHALL hold their last result between completions (see REQ-024).
REQ-019 Result SHALL satisfy hundreds*100 + tens*10 + ones == number for all 256 inputs, with every digit <= 9.

Reset
REQ-020 Assertion of rst_n=0 SHALL immediately, independent of clk, force:
- state to IDLE;
- busy=0, done=0;
- ones=tens=hundreds=0;
- scratch, shift register and counter to 0.
REQ-021 Reset asserted mid-conversion SHALL abort it with no done pulse; after rst_n deasserts, the block SHALL accept start on the next rising edge.

Configuration
REQ-022 Macro BIN2BCD_CLEAR_ON_START_EN SHALL select output behaviour at conversion start.
REQ-023 With BIN2BCD_CLEAR_ON_START_EN defined, ones/tens/hundreds SHALL be cleared to 0 on the capture edge and remain 0 until the done edge.
REQ-024 Without BIN2BCD_CLEAR_ON_START_EN, ones/tens/hundreds SHALL hold the previous result until the done edge.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- Reset, then start with number=0 -> after 8 clocks done=1, hundreds/tens/ones = 0/0/0.
- number=8'b11101111 (239), then 8'b01101111 (111), then 8'b11111111 (255) -> 2/3/9, then 1/1/1, then 2/5/5; each done is a single-cycle pulse.
- Start with 239, pulse start again with 0 while busy -> result 2/3/9 with only one done; number changes mid-conversion have no effect.
- Start asserted in the done cycle with 255 after a 111 conversion -> second done exactly 9 clocks after the first, result 2/5/5.
- rst_n pulsed low at step 4 of a 255 conversion -> no done, outputs 0 immediately; a new start with 111 then gives 1/1/1.
- Exhaustive 0..255 sweep -> digit identity holds; macro defined: outputs 0 during busy; macro undefined: outputs hold prior value during busy.
